// File: rtl/core_inst_pkg.sv
// -----------------------------------------------------------------------------
// core_inst_pkg
// Shared definitions for the per-core instruction decoder:
//   - instruction field widths and bit positions of the 21-bit core word
//   - packed struct overlay of the instruction word
//   - phase (FSM state) encoding
//   - protocol error codes
// -----------------------------------------------------------------------------
package core_inst_pkg;

  // Field widths
  localparam int INST_W = 21;
  localparam int ADDR_W = 4;
  localparam int SFP_W  = 4;

  // Bit positions inside the instruction word
  localparam int BIT_WRITE_BACK  = 20;
  localparam int BIT_FIFO_EXT_RD = 19;
  localparam int BIT_ACC         = 18;
  localparam int BIT_DIV         = 17;
  localparam int BIT_OFIFO_RD    = 16;
  localparam int VNMEM_ADD_MSB   = 15;
  localparam int VNMEM_ADD_LSB   = 12;
  localparam int PMEM_ADD_MSB    = 11;
  localparam int PMEM_ADD_LSB    = 8;
  localparam int BIT_EXECUTE     = 7;
  localparam int BIT_LOAD        = 6;
  localparam int BIT_VMEM_RD     = 5;
  localparam int BIT_VMEM_WR     = 4;
  localparam int BIT_NMEM_RD     = 3;
  localparam int BIT_NMEM_WR     = 2;
  localparam int BIT_PMEM_RD     = 1;
  localparam int BIT_PMEM_WR     = 0;

  // Overlay of the instruction word, MSB first
  typedef struct packed {
    logic              write_back;
    logic              fifo_ext_rd;
    logic              acc;
    logic              div;
    logic              ofifo_rd;
    logic [ADDR_W-1:0] vnmem_add;
    logic [ADDR_W-1:0] pmem_add;
    logic              execute;
    logic              load;
    logic              vmem_rd;
    logic              vmem_wr;
    logic              nmem_rd;
    logic              nmem_wr;
    logic              pmem_rd;
    logic              pmem_wr;
  } inst_t;

  // Phase reported on the phase output
  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_LOAD  = 3'd1,
    PH_EXEC  = 3'd2,
    PH_MOVE  = 3'd3,
    PH_READ  = 3'd4,
    PH_WRITE = 3'd5
  } phase_e;

  // Protocol error causes; a lower code wins when several occur together
  typedef enum logic [2:0] {
    ERR_NONE        = 3'd0,
    ERR_RW_CONFLICT = 3'd1,
    ERR_LOAD_EXEC   = 3'd2,
    ERR_OVERLOAD    = 3'd3,
    ERR_POP_NO_MOVE = 3'd4
  } err_e;

endpackage : core_inst_pkg

// File: rtl/core_inst_sram_strobe.sv
// -----------------------------------------------------------------------------
// core_inst_sram_strobe
// Turns one memory's rd/wr request bits and address into registered,
// active-low SRAM strobes. A simultaneous rd and wr is a protocol conflict:
// both strobes are held inactive for that instruction.
//
// Ports:
//   clk, reset   core clock, synchronous active-high reset
//   rd, wr       request bits from the current instruction
//   addr         address field from the current instruction
//   conflict     combinational: rd and wr requested together
//   rd_issued    combinational: a genuine read is launched by this instruction
//   cen, wen     registered chip-enable / write-enable, active low
//   a            registered address
// -----------------------------------------------------------------------------
module core_inst_sram_strobe
  import core_inst_pkg::*;
#(
  parameter int addr_w = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [addr_w-1:0] addr,
  output logic              conflict,
  output logic              rd_issued,
  output logic              cen,
  output logic              wen,
  output logic [addr_w-1:0] a
);

  assign conflict  = rd & wr;
  assign rd_issued = rd & ~wr;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order; blocking here would create
  // order-dependent simulation and sim/synth mismatches.
  always_ff @(posedge clk) begin
    if (reset) begin
      cen <= 1'b1;
      wen <= 1'b1;
      a   <= '0;
    end else begin
      cen <= ~(rd | wr) | conflict;
      wen <= ~wr | conflict;
      a   <= addr;
    end
  end

endmodule : core_inst_sram_strobe

// File: rtl/core_inst_decoder.sv
// -----------------------------------------------------------------------------
// core_inst_decoder
// Core-side responder for the 21-bit instruction word from the fullchip host
// or sequencer. Registers the instruction into SRAM strobes for vmem, nmem and
// pmem, aligns MAC load/execute pulses with SRAM read data (Q is valid one
// cycle after the read strobe), reports the phase and flags protocol errors.
//
// Optional feature macro: INST_PERF_CNT_EN adds saturating exec_cnt/move_cnt.
//
// Ports:
//   clk, reset               core clock, synchronous active-high reset
//   inst[20:0]               instruction word (see core_inst_pkg::inst_t)
//   vmem_cen/wen/a           vmem strobes (active low) and address
//   nmem_cen/wen/a           nmem strobes (active low) and address
//   pmem_cen/wen/a           pmem strobes (active low) and address
//   mac_load, load_idx       MAC array latches nmem Q into column load_idx
//   mac_execute              MAC array consumes vmem Q
//   ofifo_rd_o               ofifo pop (registered pass-through)
//   sfp_ctl[3:0]             registered {write_back, fifo_ext_rd, acc, div}
//   phase[2:0]               phase_e encoding
//   proto_err, err_code[2:0] sticky error flag and first error cause
//   exec_cnt, move_cnt       (INST_PERF_CNT_EN only) performance counters
// -----------------------------------------------------------------------------
module core_inst_decoder
  import core_inst_pkg::*;
#(
  parameter int col    = 8,
  parameter int pr     = 8,
  parameter int addr_w = 4,
  parameter int inst_w = 21
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [inst_w-1:0] inst,
  output logic              vmem_cen,
  output logic              vmem_wen,
  output logic [addr_w-1:0] vmem_a,
  output logic              nmem_cen,
  output logic              nmem_wen,
  output logic [addr_w-1:0] nmem_a,
  output logic              pmem_cen,
  output logic              pmem_wen,
  output logic [addr_w-1:0] pmem_a,
  output logic              mac_load,
  output logic [addr_w-1:0] load_idx,
  output logic              mac_execute,
  output logic              ofifo_rd_o,
  output logic [SFP_W-1:0]  sfp_ctl,
  output logic [2:0]        phase,
  output logic              proto_err,
  output logic [2:0]        err_code
`ifdef INST_PERF_CNT_EN
  ,
  output logic [15:0]       exec_cnt,
  output logic [15:0]       move_cnt
`endif
);

  // The field layout is fixed by core_inst_pkg; reject other configurations.
  if (col < 1 || col > (1 << addr_w) || pr < 1 ||
      inst_w != INST_W || addr_w != ADDR_W) begin : g_cfg_check
    $error("core_inst_decoder: unsupported parameter combination");
  end

  localparam logic [addr_w-1:0] COL_LAST = addr_w'(col - 1);

  inst_t d;
  assign d = inst_t'(inst);

  // ---------------------------------------------------------------------------
  // SRAM strobes (1-cycle latency)
  // ---------------------------------------------------------------------------
  logic vmem_conflict, nmem_conflict, pmem_conflict;
  logic vmem_rd_issued, nmem_rd_issued, pmem_rd_issued;

  core_inst_sram_strobe #(.addr_w(addr_w)) u_vmem_strobe (
    .clk       (clk),
    .reset     (reset),
    .rd        (d.vmem_rd),
    .wr        (d.vmem_wr),
    .addr      (d.vnmem_add),
    .conflict  (vmem_conflict),
    .rd_issued (vmem_rd_issued),
    .cen       (vmem_cen),
    .wen       (vmem_wen),
    .a         (vmem_a)
  );

  core_inst_sram_strobe #(.addr_w(addr_w)) u_nmem_strobe (
    .clk       (clk),
    .reset     (reset),
    .rd        (d.nmem_rd),
    .wr        (d.nmem_wr),
    .addr      (d.vnmem_add),
    .conflict  (nmem_conflict),
    .rd_issued (nmem_rd_issued),
    .cen       (nmem_cen),
    .wen       (nmem_wen),
    .a         (nmem_a)
  );

  // pmem reads feed the host path only, so rd_issued is not needed here.
  logic pmem_rd_unused;
  core_inst_sram_strobe #(.addr_w(addr_w)) u_pmem_strobe (
    .clk       (clk),
    .reset     (reset),
    .rd        (d.pmem_rd),
    .wr        (d.pmem_wr),
    .addr      (d.pmem_add),
    .conflict  (pmem_conflict),
    .rd_issued (pmem_rd_issued),
    .cen       (pmem_cen),
    .wen       (pmem_wen),
    .a         (pmem_a)
  );
  assign pmem_rd_unused = pmem_rd_issued;

  // ---------------------------------------------------------------------------
  // Phase, error and load-column bookkeeping
  // ---------------------------------------------------------------------------
  phase_e phase_q, phase_d;
  err_e   err_d;
  logic   ld_pend;    // registered: nmem read for a legal load in flight
  logic   ex_pend;    // registered: vmem read for a legal execute in flight
  logic   load_full;  // all col columns have been loaded this LOAD phase
  logic   full_eff;
  logic   enter_load;
  logic   load_fire;

  // A column index of col-1 currently on the output counts as the last slot.
  assign full_eff   = load_full | (mac_load & (load_idx == COL_LAST));
  assign load_fire  = ld_pend & ~full_eff;
  assign enter_load = (phase_d == PH_LOAD) && (phase_q != PH_LOAD);

  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    phase_d = PH_IDLE;
    if (d.load)                        phase_d = PH_LOAD;
    else if (d.execute)                phase_d = PH_EXEC;
    else if (d.ofifo_rd && d.pmem_wr)  phase_d = PH_MOVE;
    else if (d.pmem_rd)                phase_d = PH_READ;
    else if (d.vmem_wr || d.nmem_wr || d.pmem_wr) phase_d = PH_WRITE;

    // Written highest code first so the lowest simultaneous cause wins.
    err_d = ERR_NONE;
    if (d.ofifo_rd && !d.pmem_wr) err_d = ERR_POP_NO_MOVE;
    if (ld_pend && full_eff)      err_d = ERR_OVERLOAD;
    if (d.load && d.execute)      err_d = ERR_LOAD_EXEC;
    if (vmem_conflict || nmem_conflict || pmem_conflict) err_d = ERR_RW_CONFLICT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q     <= PH_IDLE;
      ld_pend     <= 1'b0;
      ex_pend     <= 1'b0;
      mac_load    <= 1'b0;
      mac_execute <= 1'b0;
      load_idx    <= '0;
      load_full   <= 1'b0;
      ofifo_rd_o  <= 1'b0;
      sfp_ctl     <= '0;
      proto_err   <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      phase_q    <= phase_d;
      ofifo_rd_o <= d.ofifo_rd;
      sfp_ctl    <= {d.write_back, d.fifo_ext_rd, d.acc, d.div};

      // Stage 1: remember which reads belong to a legal load/execute.
      // load+execute together suppresses both pulses.
      ld_pend <= d.load & ~d.execute & nmem_rd_issued;
      ex_pend <= d.execute & ~d.load & vmem_rd_issued;

      // Stage 2: pulse while the SRAM Q of that read is valid.
      mac_load    <= load_fire;
      mac_execute <= ex_pend;

      // load_idx names the column of the pulse on the output, then advances
      // after it; it parks at col-1 and load_full blocks further pulses.
      if (enter_load) begin
        load_idx  <= '0;
        load_full <= 1'b0;
      end else if (mac_load) begin
        if (load_idx == COL_LAST) load_full <= 1'b1;
        else                      load_idx  <= load_idx + addr_w'(1);
      end

      if (!proto_err && err_d != ERR_NONE) begin
        proto_err <= 1'b1;
        err_code  <= err_d;
      end
    end
  end

  assign phase = phase_q;

`ifdef INST_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      exec_cnt <= '0;
      move_cnt <= '0;
    end else begin
      if (mac_execute && exec_cnt != 16'hFFFF)       exec_cnt <= exec_cnt + 16'd1;
      if (phase_q == PH_MOVE && move_cnt != 16'hFFFF) move_cnt <= move_cnt + 16'd1;
    end
  end
`endif

endmodule : core_inst_decoder

// File: tb/tb_core_inst_decoder.sv
// -----------------------------------------------------------------------------
// tb_core_inst_decoder
// Directed testbench for core_inst_decoder. Instructions are applied on the
// falling edge; outputs are sampled on the following falling edge, so strobes
// reflect the instruction of the previous tick and MAC pulses the one before.
// -----------------------------------------------------------------------------
module tb_core_inst_decoder;

  localparam logic [20:0] WB    = 21'h1 << 20;
  localparam logic [20:0] OFIFO = 21'h1 << 16;
  localparam logic [20:0] EXEC  = 21'h1 << 7;
  localparam logic [20:0] LOAD  = 21'h1 << 6;
  localparam logic [20:0] VRD   = 21'h1 << 5;
  localparam logic [20:0] VWR   = 21'h1 << 4;
  localparam logic [20:0] NRD   = 21'h1 << 3;
  localparam logic [20:0] NWR   = 21'h1 << 2;
  localparam logic [20:0] PRD   = 21'h1 << 1;
  localparam logic [20:0] PWR   = 21'h1 << 0;

  logic        clk = 1'b0;
  logic        reset;
  logic [20:0] inst;
  logic        vmem_cen, vmem_wen, nmem_cen, nmem_wen, pmem_cen, pmem_wen;
  logic [3:0]  vmem_a, nmem_a, pmem_a, load_idx, sfp_ctl;
  logic        mac_load, mac_execute, ofifo_rd_o, proto_err;
  logic [2:0]  phase, err_code;

  int vectors = 0;
  int miscompares = 0;

  core_inst_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .inst        (inst),
    .vmem_cen    (vmem_cen),
    .vmem_wen    (vmem_wen),
    .vmem_a      (vmem_a),
    .nmem_cen    (nmem_cen),
    .nmem_wen    (nmem_wen),
    .nmem_a      (nmem_a),
    .pmem_cen    (pmem_cen),
    .pmem_wen    (pmem_wen),
    .pmem_a      (pmem_a),
    .mac_load    (mac_load),
    .load_idx    (load_idx),
    .mac_execute (mac_execute),
    .ofifo_rd_o  (ofifo_rd_o),
    .sfp_ctl     (sfp_ctl),
    .phase       (phase),
    .proto_err   (proto_err),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] vn(input int a);
    return 21'(a & 15) << 12;
  endfunction

  function automatic logic [20:0] pm(input int a);
    return 21'(a & 15) << 8;
  endfunction

  function automatic logic [5:0] strb();
    return {vmem_cen, vmem_wen, nmem_cen, nmem_wen, pmem_cen, pmem_wen};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [20:0] v);
    inst = v;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick('0);
    reset = 1'b0;
  endtask

  initial begin
    int pulses;
    logic [20:0] v;

    // ---- reset values and idle ----
    reset = 1'b1;
    inst  = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_strobes", 32'(strb()), 32'h3F);
    check("rst_addr", {20'd0, vmem_a, nmem_a, pmem_a}, 32'd0);
    check("rst_pulses", {mac_load, mac_execute, ofifo_rd_o}, 32'd0);
    check("rst_sfp_idx", {sfp_ctl, load_idx}, 32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_err", {proto_err, err_code}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick('0);
      check("idle_strobes", 32'(strb()), 32'h3F);
      check("idle_phase", 32'(phase), 32'd0);
      check("idle_err", 32'(proto_err), 32'd0);
    end

    // ---- nmem writes, sfp pass-through ----
    for (int a = 0; a < 8; a++) begin
      tick(NWR | vn(a) | (21'(a) << 17));
      check("nwr_strobes", 32'(strb()), 32'h33);
      check("nwr_addr", 32'(nmem_a), 32'(a));
      check("nwr_phase", 32'(phase), 32'd5);
      check("nwr_sfp", 32'(sfp_ctl), 32'(a));
    end

    // ---- load phase: 8 columns ----
    pulses = 0;
    for (int k = 0; k <= 10; k++) begin
      v = (k == 0) ? LOAD : (k <= 8) ? (LOAD | NRD | vn(k - 1)) : 21'd0;
      tick(v);
      check("ld_pulse", 32'(mac_load), (k >= 2 && k <= 9) ? 32'd1 : 32'd0);
      if (k >= 2 && k <= 9) check("ld_idx", 32'(load_idx), 32'(k - 2));
      check("ld_nstrobe", {nmem_cen, nmem_wen}, (k >= 1 && k <= 8) ? 32'd1 : 32'd3);
      check("ld_phase", 32'(phase), (k <= 8) ? 32'd1 : 32'd0);
      if (mac_load) pulses++;
    end
    check("ld_count", 32'(pulses), 32'd8);
    check("ld_noerr", 32'(proto_err), 32'd0);

    // ---- execute then move ----
    pulses = 0;
    for (int j = 0; j < 18; j++) begin
      v = (j < 8) ? (EXEC | VRD | vn(j)) : (j < 16) ? (OFIFO | PWR | pm(j - 8)) : 21'd0;
      tick(v);
      check("ex_pulse", 32'(mac_execute), (j >= 1 && j <= 8) ? 32'd1 : 32'd0);
      check("ex_phase", 32'(phase), (j < 8) ? 32'd2 : (j < 16) ? 32'd3 : 32'd0);
      if (j < 8) check("ex_vstrobe", {vmem_cen, vmem_wen}, 32'd1);
      if (j >= 8 && j < 16) begin
        check("mv_pstrobe", {pmem_cen, pmem_wen}, 32'd0);
        check("mv_addr", 32'(pmem_a), 32'(j - 8));
        check("mv_pop", 32'(ofifo_rd_o), 32'd1);
      end
      if (mac_execute) pulses++;
    end
    check("ex_count", 32'(pulses), 32'd8);
    check("ex_noerr", 32'(proto_err), 32'd0);

    // ---- rd/wr conflict, then load+execute keeps first code ----
    tick(VRD | VWR | vn(3));
    check("e1_strobes", 32'(strb()), 32'h3F);
    check("e1_err", {proto_err, err_code}, 32'h9);
    check("e1_phase", 32'(phase), 32'd5);
    tick(LOAD | EXEC | NRD | VRD);
    check("e2_phase", 32'(phase), 32'd1);
    tick('0);
    check("e2_suppr", {mac_load, mac_execute}, 32'd0);
    check("e2_keep", {proto_err, err_code}, 32'h9);

    // ---- reset mid-LOAD at load_idx 4 ----
    do_reset();
    check("rst2_err", {proto_err, err_code}, 32'd0);
    tick(LOAD);
    for (int k = 1; k <= 6; k++) tick(LOAD | NRD | vn(k - 1));
    check("mid_idx", 32'(load_idx), 32'd4);
    check("mid_pulse", 32'(mac_load), 32'd1);
    reset = 1'b1;
    tick(LOAD | NRD | vn(6));
    check("abort_idx", 32'(load_idx), 32'd0);
    check("abort_pulse", 32'(mac_load), 32'd0);
    check("abort_phase", 32'(phase), 32'd0);
    check("abort_err", 32'(proto_err), 32'd0);
    reset = 1'b0;
    tick('0);
    check("abort_nopend1", 32'(mac_load), 32'd0);
    tick('0);
    check("abort_nopend2", 32'(mac_load), 32'd0);

    // ---- load overrun: 9 reads, only 8 pulses ----
    pulses = 0;
    for (int k = 0; k <= 11; k++) begin
      v = (k == 0) ? LOAD : (k <= 9) ? (LOAD | NRD | vn(k - 1)) : 21'd0;
      tick(v);
      if (mac_load) pulses++;
      if (k == 9) check("ovr_noerr", 32'(proto_err), 32'd0);
      if (k == 10) begin
        check("ovr_suppr", 32'(mac_load), 32'd0);
        check("ovr_idx", 32'(load_idx), 32'd7);
        check("ovr_err", {proto_err, err_code}, 32'hB);
      end
    end
    check("ovr_count", 32'(pulses), 32'd8);

    // ---- pop without pmem write ----
    do_reset();
    tick(OFIFO | WB);
    check("e4_pop", 32'(ofifo_rd_o), 32'd1);
    check("e4_sfp", 32'(sfp_ctl), 32'h8);
    check("e4_err", {proto_err, err_code}, 32'hC);
    check("e4_phase", 32'(phase), 32'd0);

    // ---- simultaneous errors: lowest code wins ----
    do_reset();
    tick(OFIFO | NRD | NWR);
    check("e14_err", {proto_err, err_code}, 32'h9);
    check("e14_strobes", 32'(strb()), 32'h3F);
    check("e14_phase", 32'(phase), 32'd5);
    do_reset();
    tick(LOAD | EXEC | OFIFO);
    check("e24_err", {proto_err, err_code}, 32'hA);
    check("e24_phase", 32'(phase), 32'd1);

    // ---- pmem read phase ----
    tick(PRD | pm(5));
    check("rd_phase", 32'(phase), 32'd4);
    check("rd_strobes", 32'(strb()), 32'h3D);
    check("rd_addr", 32'(pmem_a), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_core_inst_decoder
